// File: rtl/dmem_dump_arbiter_if.sv
// rtl/dmem_dump_arbiter_if.sv - pipeline, data memory and debug dump signals around the arbiter
interface dmem_dump_arbiter_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_CNT  = 8
);
  logic [NB_ADDR-1:0] i_pipe_addr;
  logic [NB_DATA-1:0] i_pipe_wdata;
  logic               i_pipe_we;
  logic               i_pipe_re;
  logic [1:0]         i_pipe_width;
  logic               i_pipe_quiet;
  logic               o_stall_req;

  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic               o_mem_we;
  logic               o_mem_re;
  logic [1:0]         o_mem_width;
  logic [NB_DATA-1:0] i_mem_rdata;

  logic               i_dump_start;
  logic [NB_ADDR-1:0] i_dump_base;
  logic [NB_CNT-1:0]  i_dump_len;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_valid;
  logic               i_dump_ready;
  logic               o_dump_busy;
  logic               o_dump_done;
  logic               o_err;

  modport master (
    input  i_pipe_addr, i_pipe_wdata, i_pipe_we, i_pipe_re, i_pipe_width, i_pipe_quiet,
    output o_stall_req,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_mem_width,
    input  i_mem_rdata,
    input  i_dump_start, i_dump_base, i_dump_len, i_dump_ready,
    output o_dump_data, o_dump_valid, o_dump_busy, o_dump_done, o_err
  );

  modport slave (
    output i_pipe_addr, i_pipe_wdata, i_pipe_we, i_pipe_re, i_pipe_width, i_pipe_quiet,
    input  o_stall_req,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_mem_width,
    output i_mem_rdata,
    output i_dump_start, i_dump_base, i_dump_len, i_dump_ready,
    input  o_dump_data, o_dump_valid, o_dump_busy, o_dump_done, o_err
  );
endinterface

// File: rtl/dmem_dump_arbiter.sv
// rtl/dmem_dump_arbiter.sv - shares data memory between MEM stage and a debug word dump
module dmem_dump_arbiter #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_CNT  = 8
) (
  input logic clk,
  input logic i_rst_n,
  dmem_dump_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_CAPT,
    S_VALID,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [NB_ADDR-1:0] base_q;
  logic [NB_CNT-1:0]  len_q;
  logic [NB_CNT-1:0]  count_q;
  logic [NB_DATA-1:0] data_q;
  logic               err_q;

  logic [NB_CNT-1:0]  count_inc;
  logic [NB_ADDR-1:0] dbg_addr;
  logic               debug_owns;

  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [1:0]         mem_width;
  logic               stall;
  logic               dump_valid;
  logic               dump_done;

  assign count_inc  = count_q + 1'b1;
  // Word stride; the sum wraps silently at the top of the address space.
  assign dbg_addr   = base_q + (NB_ADDR'(count_q) << 2);
  assign debug_owns = (state == S_ISSUE) || (state == S_CAPT) || (state == S_VALID);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.i_dump_start) begin
        base_q  <= bus.i_dump_base;
        len_q   <= bus.i_dump_len;
        count_q <= '0;
      end
      if (state == S_CAPT) begin
        data_q <= bus.i_mem_rdata;
      end
      if (state == S_VALID && bus.i_dump_ready) begin
        count_q <= count_inc;
      end
      if (debug_owns && (bus.i_pipe_we || bus.i_pipe_re)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    mem_addr   = dbg_addr;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_width  = 2'b00;
    stall      = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;

    // Pipeline owns the memory outside the debug grant; reset forces the mirror off.
    if ((state == S_IDLE || state == S_REQ || state == S_DONE) && i_rst_n) begin
      mem_addr  = bus.i_pipe_addr;
      mem_wdata = bus.i_pipe_wdata;
      mem_we    = bus.i_pipe_we;
      mem_re    = bus.i_pipe_re;
      mem_width = bus.i_pipe_width;
    end

    case (state)
      S_IDLE: begin
        if (bus.i_dump_start) begin
          state_nx = (bus.i_dump_len != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.i_pipe_quiet) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall     = 1'b1;
        mem_re    = 1'b1;
        mem_width = 2'b10;
        state_nx  = S_CAPT;
      end
      S_CAPT: begin
        stall    = 1'b1;
        state_nx = S_VALID;
      end
      S_VALID: begin
        stall      = 1'b1;
        dump_valid = 1'b1;
        if (bus.i_dump_ready) begin
          state_nx = (count_inc == len_q) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        dump_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.o_stall_req  = stall;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = mem_wdata;
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_re     = mem_re;
  assign bus.o_mem_width  = mem_width;
  assign bus.o_dump_data  = data_q;
  assign bus.o_dump_valid = dump_valid;
  assign bus.o_dump_busy  = (state != S_IDLE);
  assign bus.o_dump_done  = dump_done;
  assign bus.o_err        = err_q;

endmodule
